// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types and constants for the external SRAM controller
package sram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LO,
        HI,
        WAIT,
        DONE
    } state_t;

    localparam int SRAM_DATA_W       = 16;
    localparam int SRAM_ADDR_W       = 18;
    localparam int DEFAULT_BASE_ADDR = 1024;

endpackage

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - sequences 32-bit MEM-stage loads/stores as two 16-bit SRAM transfers
module sram_controller
    import sram_pkg::*;
#(
    parameter int ACCESS_CYCLES = 6,
    parameter int BASE_ADDR     = DEFAULT_BASE_ADDR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_OE_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N
);

    // WAIT lasts ACCESS_CYCLES-4 cycles; the counter is loaded with one less and exits at zero.
    localparam int WAIT_LOAD = (ACCESS_CYCLES > 5) ? ACCESS_CYCLES - 5 : 0;
    localparam int CNT_W     = $clog2(ACCESS_CYCLES);

    state_t                   state, next_state;
    logic [CNT_W-1:0]         cnt;
    logic                     is_write;
    logic [SRAM_ADDR_W-2:0]   index_q;
    logic [31:0]              wdata_q;
    logic [SRAM_DATA_W-1:0]   lo_q, hi_q;
    logic                     drive;
    logic [SRAM_DATA_W-1:0]   dq_out;
    logic                     accept;

    assign accept = (state == IDLE) && (wr_en || rd_en);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (wr_en || rd_en) next_state = LO;
            LO:      next_state = HI;
            HI:      next_state = (ACCESS_CYCLES > 4) ? WAIT : DONE;
            WAIT:    if (cnt == '0) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            is_write  <= 1'b0;
            index_q   <= '0;
            wdata_q   <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
            read_data <= '0;
        end else begin
            // Write wins when both enables are high.
            if (accept) begin
                is_write <= wr_en;
                index_q  <= (SRAM_ADDR_W-1)'((address - 32'(BASE_ADDR)) >> 2);
                wdata_q  <= write_data;
            end
            if (state == HI && next_state == WAIT)
                cnt <= CNT_W'(WAIT_LOAD);
            else if (state == WAIT && cnt != '0)
                cnt <= cnt - CNT_W'(1);
            if (!is_write && state == LO) lo_q <= SRAM_DQ;
            if (!is_write && state == HI) hi_q <= SRAM_DQ;
            // Without a WAIT phase the high half is still on the bus at DONE entry.
            if (!is_write && next_state == DONE && state != DONE)
                read_data <= {(state == HI) ? SRAM_DQ : hi_q, lo_q};
        end
    end

    always_comb begin
        drive  = is_write && (state == LO || state == HI);
        dq_out = (state == HI) ? wdata_q[31:16] : wdata_q[15:0];
    end

    assign SRAM_DQ   = drive ? dq_out : {SRAM_DATA_W{1'bz}};
    assign SRAM_ADDR = {index_q, state == HI};
    assign SRAM_WE_N = !drive;
    assign SRAM_OE_N = drive;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

    assign ready = ((state == IDLE) && !wr_en && !rd_en) || (state == DONE);

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - scoreboard bench for sram_controller with a behavioural SRAM
module sram_model (
    input  logic        clk,
    inout  wire  [15:0] dq,
    input  logic [17:0] addr,
    input  logic        we_n,
    input  logic        oe_n,
    input  logic        ce_n
);
    logic [15:0] mem [0:262143];

    assign dq = (!ce_n && !oe_n && we_n) ? mem[addr] : 16'bz;

    always @(posedge clk) begin
        if (!ce_n && !we_n) mem[addr] <= dq;
    end
endmodule

module tb_sram_controller;

    typedef struct {
        logic [31:0] data;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0, rd_en = 1'b0;
    logic [31:0] address = '0, write_data = '0;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        we_n, oe_n, ce_n, ub_n, lb_n;

    logic        wr_en2 = 1'b0, rd_en2 = 1'b0;
    logic [31:0] address2 = '0, write_data2 = '0;
    logic [31:0] read_data2;
    logic        ready2;
    wire  [15:0] sram_dq2;
    logic [17:0] sram_addr2;
    logic        we_n2, oe_n2, ce_n2, ub_n2, lb_n2;

    int   vectors = 0;
    int   miscompares = 0;
    int   busy = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    sram_controller dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
        .write_data(write_data), .read_data(read_data), .ready(ready),
        .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr), .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n),
        .SRAM_CE_N(ce_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
    );

    sram_model u_mem1 (.clk(clk), .dq(sram_dq), .addr(sram_addr), .we_n(we_n), .oe_n(oe_n), .ce_n(ce_n));

    sram_controller #(.ACCESS_CYCLES(4)) dut2 (
        .clk(clk), .rst(rst), .wr_en(wr_en2), .rd_en(rd_en2), .address(address2),
        .write_data(write_data2), .read_data(read_data2), .ready(ready2),
        .SRAM_DQ(sram_dq2), .SRAM_ADDR(sram_addr2), .SRAM_WE_N(we_n2), .SRAM_OE_N(oe_n2),
        .SRAM_CE_N(ce_n2), .SRAM_UB_N(ub_n2), .SRAM_LB_N(lb_n2)
    );

    sram_model u_mem2 (.clk(clk), .dq(sram_dq2), .addr(sram_addr2), .we_n(we_n2), .oe_n(oe_n2), .ce_n(ce_n2));

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Scoreboard monitor: a rising ready after a busy stretch is one completed access.
    always @(negedge clk) begin
        if (rst) begin
            busy = 0;
        end else if (!ready) begin
            busy++;
        end else if (busy != 0) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL sb_underflow: got completion expected none");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("read_data", read_data, e.data);
                check("ready_low_cycles", busy, e.lat);
            end
            busy = 0;
        end
    end

    task automatic access(input bit wr, input bit rd, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] exp_rd,
                          input logic [17:0] hidx, input bit keep, input bit b2b,
                          input int exp_cycles);
        int  cycles;
        bit  done;
        exp_t e;
        if (!b2b) begin
            @(posedge clk); #2;
        end
        wr_en = wr; rd_en = rd; address = addr; write_data = data;
        e.data = exp_rd;
        e.lat  = 5;
        sb.push_back(e);
        cycles = 0;
        done = 0;
        for (int k = (b2b ? 0 : 1); k < 20 && !done; k++) begin
            @(posedge clk); #2;
            cycles++;
            if (k == 1) check("sram_addr_lo", 32'(sram_addr), 32'(hidx));
            if (k == 2) check("sram_addr_hi", 32'(sram_addr), 32'(hidx + 18'd1));
            check("we_n", 32'(we_n), (wr && (k == 1 || k == 2)) ? 32'd0 : 32'd1);
            if (ready) done = 1;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout: got no ready expected ready within 20 cycles");
        end
        check("access_cycles", cycles, exp_cycles);
        if (!keep) begin
            wr_en = 1'b0; rd_en = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000");
        $fatal(1);
    end

    initial begin
        int  steps;
        bit  done2;

        u_mem1.mem[2] = 16'h5678;
        u_mem1.mem[3] = 16'h1234;
        u_mem1.mem[4] = 16'hC0DE;
        u_mem1.mem[5] = 16'hCAFE;
        u_mem1.mem[6] = 16'h0BAD;
        u_mem1.mem[7] = 16'hF00D;
        u_mem2.mem[0] = 16'h2222;
        u_mem2.mem[1] = 16'h3333;

        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_we_n", 32'(we_n), 32'd1);
        check("rst_oe_n", 32'(oe_n), 32'd0);
        check("rst_read_data", read_data, 32'h0);
        check("rst_sram_addr", 32'(sram_addr), 32'h0);

        access(1, 0, 32'd1024, 32'hDEADBEEF, 32'h0, 18'd0, 0, 0, 5);
        check("mem_half0", 32'(u_mem1.mem[0]), 32'h0000BEEF);
        check("mem_half1", 32'(u_mem1.mem[1]), 32'h0000DEAD);
        access(0, 1, 32'd1024, 32'h0, 32'hDEADBEEF, 18'd0, 0, 0, 5);
        access(0, 1, 32'd1028, 32'h0, 32'h12345678, 18'd2, 0, 0, 5);
        access(0, 1, 32'd1032, 32'h0, 32'hCAFEC0DE, 18'd4, 1, 0, 5);
        access(0, 1, 32'd1036, 32'h0, 32'hF00D0BAD, 18'd6, 0, 1, 6);
        access(1, 1, 32'd1040, 32'hA5A5A5A5, 32'hF00D0BAD, 18'd8, 0, 0, 5);
        check("mem_half8", 32'(u_mem1.mem[8]), 32'h0000A5A5);
        check("mem_half9", 32'(u_mem1.mem[9]), 32'h0000A5A5);

        // Reset during the HI phase of a write.
        @(posedge clk); #2;
        wr_en = 1'b1; address = 32'd1048; write_data = 32'h41104110;
        @(posedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        wr_en = 1'b0;
        #1;
        check("midrst_ready", 32'(ready), 32'd1);
        check("midrst_we_n", 32'(we_n), 32'd1);
        check("midrst_read_data", read_data, 32'h0);
        check("midrst_sram_addr", 32'(sram_addr), 32'h0);
        check("midrst_dq_released", 32'(sram_dq), 32'h0000BEEF);
        @(posedge clk); #2 rst = 1'b0;

        // Minimum access length: no WAIT phase.
        @(posedge clk); #2;
        rd_en2 = 1'b1; address2 = 32'd1024;
        steps = 0;
        done2 = 0;
        for (int k = 0; k < 20 && !done2; k++) begin
            @(posedge clk); #2;
            steps++;
            if (ready2) done2 = 1;
        end
        check("ac4_cycles", steps, 3);
        check("ac4_read_data", read_data2, 32'h33332222);
        rd_en2 = 1'b0;

        repeat (3) @(posedge clk);
        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
# sram_controller

Sequences 32-bit memory-stage loads and stores from the ARM pipeline onto the 16-bit-wide external SRAM. Each access is performed as two half-word transfers plus a programmable wait. The controller holds `ready` low for the whole access so the hazard/freeze logic can stall every pipeline stage. It sits between the MEM stage and the SRAM pins, and replaces the single-cycle data memory.

## Interface
Parameters:
- `ACCESS_CYCLES`, default 6: cycles from request acceptance to the `ready` pulse, inclusive. Legal range is ≥ 4.
- `BASE_ADDR`, default 1024: first byte address mapped to SRAM word 0.

Ports:
- `clk` in 1: system clock. All state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `wr_en` in 1: store request from MEM stage.
- `rd_en` in 1: load request from MEM stage.
- `address` in 32: byte address, word-aligned.
- `write_data` in 32: store data.
- `read_data` out 32: load result, registered.
- `ready` out 1: high means no access is pending or the current access completes this cycle.
- `SRAM_DQ` inout 16: SRAM data bus.
- `SRAM_ADDR` out 18: SRAM half-word address.
- `SRAM_WE_N` out 1: SRAM write enable, active-low.
- `SRAM_OE_N` out 1: SRAM output enable, active-low.
- `SRAM_CE_N` out 1: tied 0.
- `SRAM_UB_N` out 1: tied 0.
- `SRAM_LB_N` out 1: tied 0.

## Operation
- FSM states and transitions:
  - IDLE: go to LO if `wr_en | rd_en`.
  - LO: always go to HI.
  - HI: go to WAIT if `ACCESS_CYCLES` > 4, else go to DONE.
  - WAIT: stay for `ACCESS_CYCLES`−4 cycles, then go to DONE.
  - DONE: always go to IDLE.
- Acceptance (IDLE with a request):
  - Register the operation type, the word index and `write_data`.
  - If `wr_en` and `rd_en` are both high, perform a write; `read_data` is unchanged.
- Word index = (`address` − `BASE_ADDR`) >> 2, truncated to 17 bits. Addresses below `BASE_ADDR` wrap modulo 2^17 words; there is no error signalling.
- LO state:
  - `SRAM_ADDR` = {index, 1'b0}.
  - Write: drive `SRAM_DQ` = wdata[15:0], `SRAM_WE_N` = 0, `SRAM_OE_N` = 1.
  - Read: `SRAM_DQ` = Z, `SRAM_WE_N` = 1, `SRAM_OE_N` = 0, and capture `SRAM_DQ` into the low-half register at the end of the cycle.
- HI state: same as LO with `SRAM_ADDR` = {index, 1'b1} and wdata[31:16]. Reads capture the high half.
- WAIT state: `SRAM_WE_N` = 1, `SRAM_OE_N` = 0, `SRAM_DQ` = Z. The wait counter counts down.
- DONE state:
  - For a read, `read_data` ← {hi, lo} is loaded on entry, so it is valid throughout DONE and holds until the next read completes.
  - For a write, `read_data` is unchanged.
- `ready` = (IDLE & !`wr_en` & !`rd_en`) | DONE. This is combinational, so the request cycle itself already shows `ready` = 0.
- The pipeline holds `address`, `write_data` and the enables stable while `ready` = 0. The controller ignores any changes after acceptance.
- A request still asserted in IDLE immediately after DONE is treated as a new access (back-to-back allowed).

## Timing
- Reset values:
  - State = IDLE; `read_data` = 0; counter = 0.
  - `SRAM_WE_N` = 1, `SRAM_OE_N` = 0, `SRAM_DQ` = Z, `SRAM_ADDR` = 0.
  - `ready` = 1 when no request is present.
- Latency: request seen at cycle 0 (IDLE); LO at 1, HI at 2, WAIT at 3..`ACCESS_CYCLES`−2, DONE at `ACCESS_CYCLES`−1. Default: `ready` is low for cycles 0–4 and high at cycle 5.
- Each SRAM half-word phase is exactly one cycle. `SRAM_WE_N` is low only during LO/HI of a write.
- Reset mid-access:
  - Return to IDLE immediately (asynchronous), release the bus and deassert `SRAM_WE_N`.
  - A partially written word in SRAM is acceptable; `read_data` is cleared to 0.
- `SRAM_DQ` is never driven in IDLE, WAIT, DONE, or during reads.

## Structure
- Shared package `sram_pkg` holds:
  - the state enum {IDLE, LO, HI, WAIT, DONE};
  - `SRAM_DATA_W` = 16 and `SRAM_ADDR_W` = 18;
  - the default `BASE_ADDR` = 1024.
- RTL is flat: one FSM, one wait counter, and the registers for the latched request and read halves. No sub-module; the tri-state is a single continuous assign.
- The bench uses a separate behavioural `sram_model` (256K×16, zero-delay read).

## Test plan
- Write 0xDEADBEEF to 1024, then read 1024: SRAM half 0 = 0xBEEF and half 1 = 0xDEAD; `read_data` = 0xDEADBEEF; `ready` low for 5 cycles on each access.
- Read of address 1028 with model preloaded to halves 2 = 0x5678 and 3 = 0x1234 → `read_data` = 0x12345678 at cycle 5; `SRAM_ADDR` 2 then 3 in cycles 1–2.
- `rd_en` held through two back-to-back reads at 1032 and 1036 → two `ready` pulses 6 cycles apart; `read_data` updates on each.
- `wr_en` and `rd_en` both high with 0xA5A5A5A5 at 1040 → write performed; `read_data` keeps its prior value.
- `rst` asserted in HI of a write → next sample shows IDLE, `SRAM_WE_N` = 1, `SRAM_DQ` = Z, `read_data` = 0, `ready` = 1.
- `ACCESS_CYCLES` = 4 → no WAIT state; `ready` high at cycle 3.
